// File: rtl/usb_tx_pkg.sv
// Shared constants and types for the full-speed USB packet transmitter.
// PID values, FSM state encoding, CRC polynomials and bit-stuffing limit.
package usb_tx_pkg;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SOF   = 4'h5;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

    typedef enum logic [1:0] {
        PKT_HS,
        PKT_TOKEN,
        PKT_DATA
    } pkt_type_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_TOKEN,
        ST_CRC5,
        ST_DATA,
        ST_CRC16,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_t;

    localparam logic [4:0]  CRC5_POLY      = 5'h05;
    localparam logic [4:0]  CRC5_INIT      = 5'h1F;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    localparam logic [7:0] SYNC_PATTERN = 8'h80;
    localparam int         STUFF_LIMIT  = 6;

    // Packet class is encoded in the two low PID bits.
    function automatic pkt_type_t pid_type(input logic [3:0] pid);
        case (pid[1:0])
            2'b01:   return PKT_TOKEN;
            2'b11:   return PKT_DATA;
            default: return PKT_HS;
        endcase
    endfunction

endpackage

// File: rtl/usb_tx_crc.sv
// Serial CRC5/CRC16 generator, one bit per bit_en_i, MSB-side feedback.
// crc_o is the inverted remainder ready to be sent MSB first.
module usb_tx_crc
    import usb_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mode_i,
    input  logic        clear_i,
    input  logic        bit_en_i,
    input  logic        data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q, crc_d;
    logic        fb;

    always_comb begin
        crc_d = crc_q;
        fb    = 1'b0;
        if (clear_i) begin
            crc_d = mode_i ? CRC16_INIT : {11'd0, CRC5_INIT};
        end else if (bit_en_i) begin
            if (mode_i) begin
                fb    = crc_q[15] ^ data_i;
                crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
            end else begin
                fb    = crc_q[4] ^ data_i;
                crc_d = {11'd0, crc_q[3:0], 1'b0} ^ {11'd0, (fb ? CRC5_POLY : 5'h00)};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_q <= '0;
        else     crc_q <= crc_d;
    end

    assign crc_o = mode_i ? ~crc_q : {11'd0, ~crc_q[4:0]};

endmodule

// File: rtl/usb_packet_tx.sv
// Full-speed USB packet transmitter: SYNC/PID/payload/CRC serialiser with
// bit stuffing, NRZI and EOP. Payload bytes are pulled one at a time.
module usb_packet_tx
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_BYTES    = 64,
    parameter int LEN_W        = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_start,
    input  logic [3:0]       tx_pid,
    input  logic [10:0]      tx_token,
    input  logic [LEN_W-1:0] tx_len,
    input  logic [7:0]       tx_data,
    input  logic             tx_data_valid,
    output logic             tx_data_ready,
    output logic             busy,
    output logic             done,
    output logic             err_underrun,
    output logic             d_plus,
    output logic             d_minus
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_t        state_q, state_d;
    pkt_type_t        type_q, type_d, start_type;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [10:0]      shreg_q, shreg_d;
    logic [3:0]       pid_q, pid_d;
    logic [10:0]      token_q, token_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [2:0]       ones_q, ones_d, ones_nxt;
    logic             stuff_q, stuff_d;
    logic             lvl_q, lvl_d;
    logic             abort_q, abort_d;

    logic        tick, in_field, raw_bit, tx_bit, line_j, se0, need_byte;
    logic        crc_clear, crc_en, crc_mode;
    logic [15:0] crc_res;
    logic [3:0]  crc_idx;

    assign tick       = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign start_type = pid_type(tx_pid);
    assign crc_mode   = (state_q == ST_IDLE) ? (start_type == PKT_DATA) : (type_q == PKT_DATA);
    assign in_field   = state_q inside {ST_SYNC, ST_PID, ST_TOKEN, ST_CRC5, ST_DATA, ST_CRC16};

    // CRC fields come straight from the generator, MSB first; others shift out LSB first.
    assign crc_idx = (state_q == ST_CRC5) ? (4'd4 - bit_q) : (4'd15 - bit_q);
    assign raw_bit = (state_q == ST_CRC5 || state_q == ST_CRC16) ? crc_res[crc_idx] : shreg_q[0];
    assign tx_bit  = raw_bit & ~stuff_q;

    usb_tx_crc u_crc (
        .clk      (clk),
        .rst      (rst),
        .mode_i   (crc_mode),
        .clear_i  (crc_clear),
        .bit_en_i (crc_en),
        .data_i   (raw_bit),
        .crc_o    (crc_res)
    );

    // NRZI: a 0 toggles the previous level, a 1 holds it. J is level 1.
    always_comb begin
        se0    = 1'b0;
        line_j = 1'b1;
        if (stuff_q || in_field) line_j = tx_bit ? lvl_q : ~lvl_q;
        else if (state_q == ST_EOP_SE0) se0 = 1'b1;
    end

    assign d_plus  = ~se0 & line_j;
    assign d_minus = ~se0 & ~line_j;
    assign busy    = (state_q != ST_IDLE);

    always_comb begin
        state_d       = state_q;
        type_d        = type_q;
        bit_d         = bit_q;
        shreg_d       = shreg_q;
        pid_d         = pid_q;
        token_d       = token_q;
        len_d         = len_q;
        ones_d        = ones_q;
        stuff_d       = stuff_q;
        lvl_d         = lvl_q;
        abort_d       = abort_q;
        need_byte     = 1'b0;
        crc_clear     = 1'b0;
        crc_en        = 1'b0;
        tx_data_ready = 1'b0;
        done          = 1'b0;
        err_underrun  = 1'b0;
        ones_nxt      = raw_bit ? (ones_q + 3'd1) : 3'd0;
        cnt_d         = (state_q == ST_IDLE || tick) ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    state_d   = ST_SYNC;
                    type_d    = start_type;
                    pid_d     = tx_pid;
                    token_d   = tx_token;
                    len_d     = (tx_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : tx_len;
                    shreg_d   = {3'b000, SYNC_PATTERN};
                    bit_d     = 4'd0;
                    ones_d    = 3'd0;
                    stuff_d   = 1'b0;
                    lvl_d     = 1'b1;
                    abort_d   = 1'b0;
                    crc_clear = 1'b1;
                end
            end
            ST_EOP_SE0: begin
                if (tick) begin
                    // A stuff bit owed by the last CRC bit goes out before SE0 starts.
                    if (stuff_q) stuff_d = 1'b0;
                    else if (bit_q == 4'd1) begin
                        state_d = ST_EOP_J;
                        bit_d   = 4'd0;
                    end else bit_d = bit_q + 4'd1;
                end
            end
            ST_EOP_J: begin
                if (tick) begin
                    done         = 1'b1;
                    err_underrun = abort_q;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                if (tick) begin
                    if (stuff_q) begin
                        stuff_d = 1'b0;
                        ones_d  = 3'd0;
                    end else begin
                        crc_en  = (state_q == ST_TOKEN) || (state_q == ST_DATA);
                        shreg_d = {1'b0, shreg_q[10:1]};
                        bit_d   = bit_q + 4'd1;
                        if (ones_nxt == 3'(STUFF_LIMIT)) begin
                            stuff_d = 1'b1;
                            ones_d  = 3'd0;
                        end else ones_d = ones_nxt;
                        case (state_q)
                            ST_SYNC: if (bit_q == 4'd7) begin
                                state_d = ST_PID;
                                bit_d   = 4'd0;
                                shreg_d = {3'b000, ~pid_q, pid_q};
                            end
                            ST_PID: if (bit_q == 4'd7) begin
                                bit_d = 4'd0;
                                case (type_q)
                                    PKT_TOKEN: begin
                                        state_d = ST_TOKEN;
                                        shreg_d = token_q;
                                    end
                                    PKT_DATA: begin
                                        if (len_q == '0) state_d = ST_CRC16;
                                        else need_byte = 1'b1;
                                    end
                                    default: state_d = ST_EOP_SE0;
                                endcase
                            end
                            ST_TOKEN: if (bit_q == 4'd10) begin
                                state_d = ST_CRC5;
                                bit_d   = 4'd0;
                            end
                            ST_CRC5: if (bit_q == 4'd4) begin
                                state_d = ST_EOP_SE0;
                                bit_d   = 4'd0;
                            end
                            ST_DATA: if (bit_q == 4'd7) begin
                                bit_d = 4'd0;
                                if (len_q == '0) state_d = ST_CRC16;
                                else need_byte = 1'b1;
                            end
                            ST_CRC16: if (bit_q == 4'd15) begin
                                state_d = ST_EOP_SE0;
                                bit_d   = 4'd0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase

        if (tick && (stuff_q || in_field)) lvl_d = line_j;

        // Byte fetch; a missing byte aborts straight into EOP with no CRC.
        if (need_byte) begin
            tx_data_ready = 1'b1;
            if (tx_data_valid) begin
                state_d = ST_DATA;
                shreg_d = {3'b000, tx_data};
                len_d   = len_q - LEN_W'(1);
            end else begin
                state_d = ST_EOP_SE0;
                bit_d   = 4'd0;
                stuff_d = 1'b0;
                ones_d  = 3'd0;
                abort_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            type_q  <= PKT_HS;
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            shreg_q <= '0;
            pid_q   <= 4'd0;
            token_q <= '0;
            len_q   <= '0;
            ones_q  <= 3'd0;
            stuff_q <= 1'b0;
            lvl_q   <= 1'b1;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            pid_q   <= pid_d;
            token_q <= token_d;
            len_q   <= len_d;
            ones_q  <= ones_d;
            stuff_q <= stuff_d;
            lvl_q   <= lvl_d;
            abort_q <= abort_d;
        end
    end

endmodule

// File: tb/tb_usb_packet_tx.sv
// Directed bench for usb_packet_tx: captures the line per bit time, decodes
// NRZI and bit stuffing, and checks fields and handshake timing.
module tb_usb_packet_tx;

    localparam int CPB  = 8;
    localparam int MAXB = 64;
    localparam int LW   = $clog2(MAXB + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_start;
    logic [3:0]    tx_pid;
    logic [10:0]   tx_token;
    logic [LW-1:0] tx_len;
    logic [7:0]    tx_data;
    logic          tx_data_valid;
    logic          tx_data_ready, busy, done, err_underrun, d_plus, d_minus;

    usb_packet_tx #(.CLKS_PER_BIT(CPB), .MAX_BYTES(MAXB)) dut (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_pid(tx_pid),
        .tx_token(tx_token), .tx_len(tx_len), .tx_data(tx_data),
        .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
        .busy(busy), .done(done), .err_underrun(err_underrun),
        .d_plus(d_plus), .d_minus(d_minus)
    );

    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    string syms;
    int    se0_cycles, first_se0, done_cyc, done_cnt, err_cnt, err_cyc, rdy_cnt, n_cyc, drop_at;
    logic  busy_first, busy_after;
    logic [7:0] bytes [0:7];
    logic  rx [0:255];
    int    nraw, nstuff, stuff_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_str(input string tag, input string obs, input string exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: got %s expected %s", tag, obs, exp);
        end
    endtask

    // Starts one packet and samples each cycle (n=1 is the cycle after accept)
    // until the cycle after done or the budget runs out.
    task automatic run_pkt(input logic [3:0] pid, input logic [10:0] tok,
                           input logic [LW-1:0] len, input int budget);
        int   idx;
        logic pend, se;
        syms = ""; se0_cycles = 0; first_se0 = 0; done_cyc = 0; done_cnt = 0;
        err_cnt = 0; err_cyc = 0; rdy_cnt = 0; busy_first = 1'b0; busy_after = 1'b1;
        idx = 0; pend = 1'b0;
        tx_data = bytes[0];
        tx_data_valid = (drop_at > 1);
        @(negedge clk);
        tx_pid = pid; tx_token = tok; tx_len = len; tx_start = 1'b1;
        @(posedge clk);
        n_cyc = 0;
        while (n_cyc < budget) begin
            @(negedge clk);
            n_cyc++;
            tx_start = 1'b0;
            if (pend) begin
                if (idx < 7) idx++;
                tx_data = bytes[idx];
                tx_data_valid = (rdy_cnt + 1 < drop_at);
                pend = 1'b0;
            end
            if (n_cyc == 1) busy_first = busy;
            if (tx_data_ready) begin rdy_cnt++; pend = 1'b1; end
            se = !d_plus && !d_minus;
            if (se) begin
                se0_cycles++;
                if (first_se0 == 0) first_se0 = n_cyc;
            end
            if (err_underrun) begin err_cnt++; err_cyc = n_cyc; end
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = n_cyc;
            end
            if (done_cyc != 0 && n_cyc == done_cyc + 1) begin
                busy_after = busy;
                break;
            end
            if ((n_cyc - 1) % CPB == CPB / 2)
                syms = $sformatf("%s%s", syms, se ? "0" : (d_plus && !d_minus) ? "J" :
                                 (!d_plus && d_minus) ? "K" : "X");
        end
        chk("done_within_budget", 32'(done_cyc != 0), 32'd1);
    endtask

    // Receiver: NRZI decode from J, then drop the bit following six 1s.
    task automatic decode();
        byte prev, c;
        int  ones;
        logic b;
        prev = "J"; nraw = 0; nstuff = 0; stuff_bad = 0; ones = 0;
        for (int i = 0; i < syms.len(); i++) begin
            c = syms[i];
            if (c == "0") break;
            b = (c == prev);
            prev = c;
            if (ones == 6) begin
                nstuff++;
                if (b) stuff_bad++;
                ones = 0;
            end else begin
                rx[nraw] = b;
                nraw++;
                ones = b ? ones + 1 : 0;
            end
        end
    endtask

    function automatic logic [15:0] field(input int start, input int w, input bit msb_first);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < w; i++) begin
            if (msb_first) v = {v[14:0], rx[start + i]};
            else           v[i] = rx[start + i];
        end
        return v;
    endfunction

    function automatic logic [15:0] rx_residual16();
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 16; i < nraw; i++) begin
            fb = c[15] ^ rx[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
        return c;
    endfunction

    initial begin
        string ack_syms;
        int    toggles;
        ack_syms = "KJKJKJKKJJKJJKKK00J";
        rst = 1'b1; tx_start = 1'b0; tx_pid = 4'h0; tx_token = '0; tx_len = '0;
        tx_data = 8'h00; tx_data_valid = 1'b0; drop_at = 99;
        for (int i = 0; i < 8; i++) bytes[i] = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_dplus", 32'(d_plus), 32'd1);
        chk("rst_dminus", 32'(d_minus), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(tx_data_ready), 32'd0);
        chk("rst_err", 32'(err_underrun), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ACK handshake
        run_pkt(4'h2, 11'h000, '0, 400);
        chk_str("ack_line", syms, ack_syms);
        chk("ack_done_cycle", 32'(done_cyc), 32'd152);
        chk("ack_done_pulses", 32'(done_cnt), 32'd1);
        chk("ack_busy_first", 32'(busy_first), 32'd1);
        chk("ack_busy_after", 32'(busy_after), 32'd0);
        chk("ack_se0_cycles", 32'(se0_cycles), 32'd16);
        chk("ack_first_se0", 32'(first_se0), 32'd129);
        chk("ack_ready", 32'(rdy_cnt), 32'd0);

        // IN token, addr 0x15 endp 0xE
        run_pkt(4'h9, 11'h715, '0, 600);
        decode();
        chk("in_raw_bits", 32'(nraw), 32'd32);
        chk("in_sync", 32'(field(0, 8, 0)), 32'h80);
        chk("in_pid", 32'(field(8, 8, 0)), 32'h69);
        chk("in_token", 32'(field(16, 11, 0)), 32'h715);
        chk("in_crc5", 32'(field(27, 5, 1)), 32'h17);
        chk("in_err", 32'(err_cnt), 32'd0);
        chk("in_done_cycle", 32'(done_cyc), 32'd280);

        // DATA0, zero length
        run_pkt(4'h3, 11'h000, '0, 600);
        decode();
        toggles = 0;
        for (int i = 16; i < 32; i++) if (syms[i] != syms[i-1]) toggles++;
        chk("d0_raw_bits", 32'(nraw), 32'd32);
        chk("d0_pid", 32'(field(8, 8, 0)), 32'hC3);
        chk("d0_crc16", 32'(field(16, 16, 1)), 32'h0000);
        chk("d0_toggles", 32'(toggles), 32'd16);
        chk("d0_ready", 32'(rdy_cnt), 32'd0);

        // DATA1, FF FF: heavy stuffing in payload and CRC
        bytes[0] = 8'hFF; bytes[1] = 8'hFF;
        run_pkt(4'hB, 11'h000, LW'(2), 900);
        decode();
        chk("d1_raw_bits", 32'(nraw), 32'd48);
        chk("d1_stuffs", 32'(nstuff), 32'd5);
        chk("d1_stuff_zero", 32'(stuff_bad), 32'd0);
        chk("d1_pid", 32'(field(8, 8, 0)), 32'h4B);
        chk("d1_byte0", 32'(field(16, 8, 0)), 32'hFF);
        chk("d1_byte1", 32'(field(24, 8, 0)), 32'hFF);
        chk("d1_ready", 32'(rdy_cnt), 32'd2);
        chk("d1_residual", 32'(rx_residual16()), 32'h800D);
        chk("d1_done_cycle", 32'(done_cyc), 32'd448);
        chk("d1_err", 32'(err_cnt), 32'd0);

        // DATA0 len 4, valid withdrawn at the third fetch
        bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03; bytes[3] = 8'h04;
        drop_at = 3;
        run_pkt(4'h3, 11'h000, LW'(4), 900);
        decode();
        chk("ur_ready", 32'(rdy_cnt), 32'd3);
        chk("ur_err_pulses", 32'(err_cnt), 32'd1);
        chk("ur_err_with_done", 32'(err_cyc), 32'(done_cyc));
        chk("ur_raw_bits", 32'(nraw), 32'd32);
        chk("ur_byte0", 32'(field(16, 8, 0)), 32'h01);
        chk("ur_byte1", 32'(field(24, 8, 0)), 32'h02);
        chk("ur_first_se0", 32'(first_se0), 32'd257);
        chk("ur_done_cycle", 32'(done_cyc), 32'd280);
        drop_at = 99;

        // Reset in the middle of the PID field (bit 10 is a K)
        @(negedge clk);
        tx_pid = 4'h2; tx_len = '0; tx_start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 84; n++) begin
            @(negedge clk);
            tx_start = 1'b0;
        end
        chk("mid_pid_is_k", 32'({d_plus, d_minus}), 32'b01);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_dplus", 32'(d_plus), 32'd1);
        chk("mid_rst_dminus", 32'(d_minus), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_pkt(4'h2, 11'h000, '0, 400);
        chk_str("post_rst_ack_line", syms, ack_syms);
        chk("post_rst_done_cycle", 32'(done_cyc), 32'd152);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usb_packet_tx.md
Name: usb_packet_tx

Overview:
Parametrised full-speed USB packet transmitter and the successor to the fixed 64-bit transmitter top.
- Serialises token, data and handshake packets: SYNC, PID, payload, then CRC5 or CRC16 generated on the fly.
- Applies bit stuffing and NRZI encoding, then drives EOP.
- Payload is streamed byte-wise through a valid/ready handshake, up to MAX_BYTES bytes. It is not preloaded as a fixed 64-bit word.
- Sits between the packet/encryption layer and the D+/D- pads.

Parameters:
CLKS_PER_BIT, 8, clk cycles per USB bit time (must be >= 2)
MAX_BYTES, 64, maximum data payload length in bytes
LEN_W, $clog2(MAX_BYTES+1), width of tx_len (derived; do not override)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
tx_start  in  1  one-cycle request to send a packet; sampled only in IDLE
tx_pid  in  4  PID nibble; the type is selected by tx_pid[1:0]: 01 token, 11 data, 10/00 handshake (PID only)
tx_token  in  11  token field {endp[3:0],addr[6:0]}; sent LSB first; latched at start
tx_len  in  LEN_W  data payload byte count; latched at start; values above MAX_BYTES are clamped to MAX_BYTES
tx_data  in  8  payload byte
tx_data_valid  in  1  tx_data is valid
tx_data_ready  out  1  one-cycle pulse; tx_data is consumed in this cycle
busy  out  1  packet in progress, from the cycle after accept until after done
done  out  1  one-cycle pulse at the end of the EOP J bit
err_underrun  out  1  one-cycle pulse, coincident with done, when the packet was aborted
d_plus  out  1  D+ line
d_minus  out  1  D- line

Behaviour:
- Reset (async, any time, including mid-packet):
  - State returns to IDLE.
  - d_plus=1, d_minus=0 (J), immediately.
  - busy, done, tx_data_ready and err_underrun are all 0.
  - Stuff counter and bit timer are cleared.
- Bit timing: a bit-timer counts 0..CLKS_PER_BIT-1. Line values change only on a bit boundary.
- Start latency: the first SYNC bit is driven starting 1 cycle after tx_start is accepted.
- tx_start while busy is ignored. There is no queueing.
- States: IDLE -> SYNC(8) -> PID(8) -> {TOKEN(11) -> CRC5(5) | DATA(8*len) -> CRC16(16) | none} -> EOP_SE0(2) -> EOP_J(1) -> IDLE.
  - Counts in brackets are raw bit times, excluding stuffed bits.
- Field encoding (all fields LSB first except CRCs):
  - SYNC is 8'h80, i.e. 7 zeros then a 1.
  - PID byte is {~tx_pid, tx_pid}.
- CRC5: polynomial x^5+x^2+1, initialised to 5'b11111, computed over the 11 token bits. The result is inverted and sent MSB first.
- CRC16: polynomial 0x8005, initialised to 16'hFFFF, computed over the payload bits. The result is inverted and sent MSB first.
- len=0 DATA packet: PID is followed directly by CRC16, which equals 16'h0000.
- Payload fetch:
  - tx_data_ready pulses on the clock of the bit boundary where the shifter needs its next byte.
  - If tx_data_valid=0 in that cycle, the packet aborts: the transmitter goes straight to EOP_SE0 with no CRC, and err_underrun pulses together with done.
- Bit stuffing:
  - The counter tracks consecutive raw 1s from the SYNC field through the last CRC bit.
  - After the sixth 1, a 0 is inserted for one bit time and the counter clears.
  - A stuff bit that falls due after the final CRC bit is still sent before EOP.
  - The field/bit counters and CRC calculation pause during a stuffed bit.
  - A raw 0 clears the counter.
- NRZI: a 0 toggles the J/K level, a 1 holds it. Encoding starts from J (d_plus=1, d_minus=0).
- EOP: SE0 (both lines 0) for 2 bit times, then J for 1 bit time, then IDLE.
- busy is cleared in the cycle after done.

Decomposition:
- usb_tx_pkg holds:
  - PID constants (OUT/IN/SOF/SETUP/DATA0/DATA1/ACK/NAK/STALL);
  - the packet-type enum and the tx_state_t enum;
  - CRC5/CRC16 polynomials, init and residual constants;
  - the SYNC pattern;
  - the STUFF_LIMIT=6 constant.
- One sub-module, usb_tx_crc: a serial CRC5/CRC16 generator with mode select, clear, bit_en, data_in, and the inverted result.

Test Plan:
- ACK (tx_pid=4'h2), CLKS_PER_BIT=8:
  - Line shows KJKJKJKK for SYNC.
  - PID bits are 01001011 (LSB first), NRZI-encoded.
  - Then SE0 for 16 cycles and J for 8 cycles.
  - done pulses exactly at cycle 1+(8+8+3)*8-1 after accept.
- IN token (tx_pid=4'h9), addr=7'h15, endp=4'hE -> decoded CRC5 field equals 5'h17. No err_underrun.
- DATA0 (tx_pid=4'h3), len=0 -> 16 zero CRC bits, so the line toggles every bit time for 16 bits. Exactly 0 tx_data_ready pulses.
- DATA1 with len=2, bytes 8'hFF,8'hFF:
  - A stuffed 0 appears after every 6th consecutive 1.
  - The decoded payload still equals FF FF.
  - Exactly 2 ready pulses.
  - The receiver-side CRC16 residual equals 16'h800D.
- Underrun: DATA0 with len=4, valid dropped at the 3rd ready pulse:
  - Immediate SE0 with no CRC bits.
  - err_underrun and done pulse in the same cycle.
- rst asserted mid-PID:
  - Lines go to J within the same cycle; busy is 0.
  - A new tx_start after rst falls produces a complete, correct ACK packet.
